// File: rtl/spm_arb_pkg.sv
// Shared encodings for the scratch pad B-port arbiter: active-low strobes,
// access direction, read-return owner and the starvation counter helper.
package spm_arb_pkg;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;
  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;

  localparam int SPM_OWNER_W  = 2;
  localparam int SPM_STARVE_W = 4;

  typedef enum logic [SPM_OWNER_W-1:0] {
    SPM_OWNER_NONE = 2'd0,
    SPM_OWNER_MEM  = 2'd1,
    SPM_OWNER_BUS  = 2'd2
  } spm_owner_e;

  // Saturating increment used by the starvation guard.
  function automatic logic [SPM_STARVE_W-1:0] starve_inc(
    input logic [SPM_STARVE_W-1:0] cnt,
    input logic [SPM_STARVE_W-1:0] lim
  );
    return (cnt >= lim) ? lim : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/spm_arb.sv
// Arbiter sharing the scratch pad B port between MEM (fixed priority) and the
// bus master, with a starvation guard and one-cycle-late read-return routing.
module spm_arb
  import spm_arb_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              mem_as_,
  input  logic              mem_rw,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wr_data,
  output logic              mem_rdy_,
  output logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_rd_vld_,
  input  logic              bus_as_,
  input  logic              bus_rw,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_wr_data,
  output logic              bus_rdy_,
  output logic [DATA_W-1:0] bus_rd_data,
  output logic              bus_rd_vld_,
  output logic              spm_as_,
  output logic              spm_rw,
  output logic [ADDR_W-1:0] spm_addr,
  output logic [DATA_W-1:0] spm_wr_data,
  input  logic [DATA_W-1:0] spm_rd_data
);

  localparam logic [SPM_STARVE_W-1:0] STARVE_LIM = SPM_STARVE_W'(STARVE_MAX);

  logic                    mem_req;
  logic                    bus_req;
  spm_owner_e              grant;
  spm_owner_e              rd_owner;
  spm_owner_e              rd_owner_next;
  logic [SPM_STARVE_W-1:0] starve_cnt;
  logic [SPM_STARVE_W-1:0] starve_cnt_next;

  assign mem_req = (mem_as_ == ENABLE_);
  assign bus_req = (bus_as_ == ENABLE_);

  // Grant is gated by reset_ so the port goes idle the moment reset asserts.
  always_comb begin
    grant = SPM_OWNER_NONE;
    if (reset_) begin
      if (bus_req && (starve_cnt == STARVE_LIM)) grant = SPM_OWNER_BUS;
      else if (mem_req)                          grant = SPM_OWNER_MEM;
      else if (bus_req)                          grant = SPM_OWNER_BUS;
    end
  end

  always_comb begin
    spm_as_     = DISABLE_;
    spm_rw      = READ;
    spm_addr    = '0;
    spm_wr_data = '0;
    mem_rdy_    = DISABLE_;
    bus_rdy_    = DISABLE_;
    case (grant)
      SPM_OWNER_MEM: begin
        spm_as_     = ENABLE_;
        spm_rw      = mem_rw;
        spm_addr    = mem_addr;
        spm_wr_data = mem_wr_data;
        mem_rdy_    = ENABLE_;
      end
      SPM_OWNER_BUS: begin
        spm_as_     = ENABLE_;
        spm_rw      = bus_rw;
        spm_addr    = bus_addr;
        spm_wr_data = bus_wr_data;
        bus_rdy_    = ENABLE_;
      end
      default: ;
    endcase
  end

  always_comb begin
    starve_cnt_next = starve_cnt;
    if (!bus_req || (grant == SPM_OWNER_BUS)) starve_cnt_next = '0;
    else if (grant == SPM_OWNER_MEM)          starve_cnt_next = starve_inc(starve_cnt, STARVE_LIM);
  end

  always_comb begin
    rd_owner_next = SPM_OWNER_NONE;
    if ((grant != SPM_OWNER_NONE) && (spm_rw == READ)) rd_owner_next = grant;
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      starve_cnt <= '0;
      rd_owner   <= SPM_OWNER_NONE;
    end else begin
      starve_cnt <= starve_cnt_next;
      rd_owner   <= rd_owner_next;
    end
  end

  // Block RAM data is broadcast; only the valid strobe is steered.
  assign mem_rd_data = spm_rd_data;
  assign bus_rd_data = spm_rd_data;
  assign mem_rd_vld_ = (rd_owner == SPM_OWNER_MEM) ? ENABLE_ : DISABLE_;
  assign bus_rd_vld_ = (rd_owner == SPM_OWNER_BUS) ? ENABLE_ : DISABLE_;

endmodule

// File: tb/tb_spm_arb.sv
// Self-checking bench for spm_arb: directed scenarios plus randomized traffic
// compared against a behavioural arbitration/memory model.
module tb_spm_arb;
  import spm_arb_pkg::*;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          reset_ = 1'b0;
  logic          mem_as_ = 1'b1, mem_rw = 1'b1;
  logic [AW-1:0] mem_addr = '0;
  logic [DW-1:0] mem_wr_data = '0;
  logic          mem_rdy_, mem_rd_vld_;
  logic [DW-1:0] mem_rd_data;
  logic          bus_as_ = 1'b1, bus_rw = 1'b1;
  logic [AW-1:0] bus_addr = '0;
  logic [DW-1:0] bus_wr_data = '0;
  logic          bus_rdy_, bus_rd_vld_;
  logic [DW-1:0] bus_rd_data;
  logic          spm_as_, spm_rw;
  logic [AW-1:0] spm_addr;
  logic [DW-1:0] spm_wr_data;
  logic [DW-1:0] spm_rd_data = '0;

  always #5 clk = ~clk;

  spm_arb #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset_(reset_),
    .mem_as_(mem_as_), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rdy_(mem_rdy_), .mem_rd_data(mem_rd_data), .mem_rd_vld_(mem_rd_vld_),
    .bus_as_(bus_as_), .bus_rw(bus_rw), .bus_addr(bus_addr), .bus_wr_data(bus_wr_data),
    .bus_rdy_(bus_rdy_), .bus_rd_data(bus_rd_data), .bus_rd_vld_(bus_rd_vld_),
    .spm_as_(spm_as_), .spm_rw(spm_rw), .spm_addr(spm_addr), .spm_wr_data(spm_wr_data),
    .spm_rd_data(spm_rd_data)
  );

  // Environment: the scratch pad itself, one-cycle registered read.
  logic [DW-1:0] spm_ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (spm_as_ == 1'b0) begin
      if (spm_rw == 1'b0) spm_ram[spm_addr] <= spm_wr_data;
      else                spm_rd_data <= spm_ram[spm_addr];
    end
  end

  // Reference model state.
  logic [DW-1:0] mdl_mem [0:(1<<AW)-1];
  int            mdl_cnt = 0;
  int            pend_owner = 0;   // 0 none, 1 MEM, 2 BUS
  logic [DW-1:0] pend_data = '0;
  int            last_grant = 0;
  bit            lost_mem = 0, lost_bus = 0;
  int            n_checks = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  // One clock cycle: drive requests, check at the falling edge, advance model.
  task automatic step(input logic m_as, input logic m_rw, input logic [AW-1:0] m_a,
                      input logic [DW-1:0] m_d, input logic b_as, input logic b_rw,
                      input logic [AW-1:0] b_a, input logic [DW-1:0] b_d);
    int            g;
    logic          e_rw;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_d;
    mem_as_ = m_as; mem_rw = m_rw; mem_addr = m_a; mem_wr_data = m_d;
    bus_as_ = b_as; bus_rw = b_rw; bus_addr = b_a; bus_wr_data = b_d;
    if (!b_as && mdl_cnt == SM) g = 2;
    else if (!m_as)             g = 1;
    else if (!b_as)             g = 2;
    else                        g = 0;
    e_rw = (g == 1) ? m_rw : (g == 2) ? b_rw : 1'b1;
    e_a  = (g == 1) ? m_a  : (g == 2) ? b_a  : '0;
    e_d  = (g == 1) ? m_d  : (g == 2) ? b_d  : '0;
    @(negedge clk);
    check_eq("mem_rdy_", 64'(mem_rdy_), 64'(g != 1));
    check_eq("bus_rdy_", 64'(bus_rdy_), 64'(g != 2));
    check_eq("spm_as_", 64'(spm_as_), 64'(g == 0));
    check_eq("spm_rw", 64'(spm_rw), 64'(e_rw));
    check_eq("spm_addr", 64'(spm_addr), 64'(e_a));
    check_eq("spm_wr_data", 64'(spm_wr_data), 64'(e_d));
    check_eq("mem_rd_vld_", 64'(mem_rd_vld_), 64'(pend_owner != 1));
    check_eq("bus_rd_vld_", 64'(bus_rd_vld_), 64'(pend_owner != 2));
    if (pend_owner == 1) check_eq("mem_rd_data", 64'(mem_rd_data), 64'(pend_data));
    if (pend_owner == 2) check_eq("bus_rd_data", 64'(bus_rd_data), 64'(pend_data));
    check_eq("starve_cnt", 64'(dut.starve_cnt), 64'(mdl_cnt));
    $display("cyc t=%0t mem_as_=%0b bus_as_=%0b grant=%0d rd_owner=%0d cnt=%0d",
             $time, m_as, b_as, g, pend_owner, mdl_cnt);
    @(posedge clk);
    pend_owner = (g != 0 && e_rw == 1'b1) ? g : 0;
    if (g != 0 && e_rw == 1'b1) pend_data = mdl_mem[e_a];
    if (g != 0 && e_rw == 1'b0) mdl_mem[e_a] = e_d;
    if (b_as || g == 2) mdl_cnt = 0;
    else if (g == 1)    mdl_cnt = (mdl_cnt + 1 > SM) ? SM : mdl_cnt + 1;
    last_grant = g;
    lost_mem = !m_as && g != 1;
    lost_bus = !b_as && g != 2;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 1, '0, '0, 1, 1, '0, '0);
  endtask

  logic [9:0]    bus_won;
  logic          r_m_as, r_m_rw, r_b_as, r_b_rw;
  logic [AW-1:0] r_m_a, r_b_a;
  logic [DW-1:0] r_m_d, r_b_d;

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      spm_ram[i] = $urandom;
      mdl_mem[i] = spm_ram[i];
    end
    // Reset with both requesting: everything must stay idle.
    mem_as_ = 1'b0; bus_as_ = 1'b0; mem_addr = 12'h0AA; bus_addr = 12'h055;
    #3;
    check_eq("rst spm_as_", 64'(spm_as_), 64'(1));
    check_eq("rst spm_addr", 64'(spm_addr), 64'(0));
    check_eq("rst mem_rdy_", 64'(mem_rdy_), 64'(1));
    check_eq("rst bus_rdy_", 64'(bus_rdy_), 64'(1));
    check_eq("rst mem_rd_vld_", 64'(mem_rd_vld_), 64'(1));
    check_eq("rst bus_rd_vld_", 64'(bus_rd_vld_), 64'(1));
    @(posedge clk); #1;
    reset_ = 1'b1;

    // Bus writes 0xDEADBEEF to 0x010, then MEM reads it alone.
    step(1, 1, '0, '0, 0, 0, 12'h010, 32'hDEADBEEF);
    step(0, 1, 12'h010, '0, 1, 1, '0, '0);
    check_eq("mem read data", 64'(pend_data), 64'(32'hDEADBEEF));
    idle(1);

    // Both request continuously: expect M,M,M,M,B,M,M,M,M,B.
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 12'h020, '0, 0, 1, 12'h030, '0);
      bus_won[i] = (last_grant == 2);
    end
    check_eq("starve sequence", 64'(bus_won), 64'(10'b1000010000));
    idle(1);

    // Bus write then MEM read of the same word on the next cycle.
    step(1, 1, '0, '0, 0, 0, 12'h0FF, 32'h12345678);
    step(0, 1, 12'h0FF, '0, 1, 1, '0, '0);
    idle(1);

    // Alternating bus / MEM reads.
    for (int i = 0; i < 3; i++) begin
      step(1, 1, '0, '0, 0, 1, 12'h001, '0);
      step(0, 1, 12'h002, '0, 1, 1, '0, '0);
    end
    idle(10);

    // Asynchronous reset in the cycle following a granted MEM read.
    step(0, 1, 12'h010, '0, 1, 1, '0, '0);
    mem_as_ = 1'b0; bus_as_ = 1'b0; mem_rw = 1'b0; mem_addr = 12'h123;
    #2 reset_ = 1'b0;
    #1;
    check_eq("arst spm_as_", 64'(spm_as_), 64'(1));
    check_eq("arst spm_rw", 64'(spm_rw), 64'(1));
    check_eq("arst spm_addr", 64'(spm_addr), 64'(0));
    check_eq("arst spm_wr_data", 64'(spm_wr_data), 64'(0));
    check_eq("arst mem_rdy_", 64'(mem_rdy_), 64'(1));
    check_eq("arst mem_rd_vld_", 64'(mem_rd_vld_), 64'(1));
    check_eq("arst starve_cnt", 64'(dut.starve_cnt), 64'(0));
    @(posedge clk); @(posedge clk); #1;
    reset_ = 1'b1;
    mdl_cnt = 0; pend_owner = 0; lost_mem = 0; lost_bus = 0;
    idle(2);

    // Randomized traffic; a requester that lost keeps its request stable.
    r_m_as = 1; r_m_rw = 1; r_m_a = '0; r_m_d = '0;
    r_b_as = 1; r_b_rw = 1; r_b_a = '0; r_b_d = '0;
    for (int i = 0; i < 400; i++) begin
      if (!lost_mem) begin
        r_m_as = ($urandom_range(0, 9) < 4);
        r_m_rw = $urandom_range(0, 1);
        r_m_a  = AW'($urandom_range(0, 15));
        r_m_d  = $urandom;
      end
      if (!lost_bus) begin
        r_b_as = ($urandom_range(0, 9) < 4);
        r_b_rw = $urandom_range(0, 1);
        r_b_a  = AW'($urandom_range(0, 15));
        r_b_d  = $urandom;
      end
      step(r_m_as, r_m_rw, r_m_a, r_m_d, r_b_as, r_b_rw, r_b_a, r_b_d);
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
